// File: rtl/key_event_pkg.sv
// Shared types and sizing helpers for the key event decoder.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_evt_state_t;

  // Hold counter must reach the larger of the two thresholds without wrapping.
  function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
    int m;
    m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Free-running timebase divider: one-cycle tick every DIV clocks, restartable by i_clr.
module key_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == PW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clr || o_tick) cnt_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/click/long/repeat pulses.
// Auto-repeat is built only when KEY_EVT_AUTOREPEAT_EN is defined.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int F_CLK        = 50000000,
  parameter int F_TICK       = 1000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_state,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int DIV   = F_CLK / F_TICK;
  localparam int CNT_W = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

  key_evt_state_t   state_q, state_d;
  logic             key_q, fall, rise, tick;
  logic             long_hit, rep_hit, cnt_en;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             press_d, release_d, click_d, long_d, repeat_d, held_d;
  logic             press_q, release_q, click_q, long_q, repeat_q, held_q;

  assign fall = key_q & ~i_key_state;
  assign rise = ~key_q & i_key_state;

  // Restarting the divider on the press aligns hold timing to the press itself.
  key_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (fall),
    .o_tick (tick)
  );

  assign long_hit = tick && (tick_cnt_q == LONG_LAST);

`ifdef KEY_EVT_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
  assign rep_hit = tick && (tick_cnt_q == REP_LAST);
  assign cnt_en  = tick && (state_q != IDLE);
`else
  assign rep_hit = 1'b0;
  assign cnt_en  = tick && (state_q == PRESSED);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      key_q      <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= i_key_state;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = PRESSED;
      PRESSED: begin
        if (rise)          state_d = IDLE;
        else if (long_hit) state_d = LONG;
      end
      LONG:    if (rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A release in the same cycle as a threshold suppresses the threshold event.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE:    press_d = fall;
      PRESSED: begin
        release_d = rise;
        click_d   = rise;
        long_d    = ~rise & long_hit;
      end
      LONG: begin
        release_d = rise;
        repeat_d  = ~rise & rep_hit;
      end
      default: ;
    endcase
    held_d = (state_d != IDLE);
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (fall || long_d || repeat_d) tick_cnt_d = '0;
    else if (cnt_en)                tick_cnt_d = tick_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_held    = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: hold-duration reference model plus event monitor.
module tb_key_event_decoder;

  localparam int F_CLK        = 1000;
  localparam int F_TICK       = 100;
  localparam int LONG_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;
  localparam int DIV          = F_CLK / F_TICK;
  localparam int LONG_CYC     = LONG_TICKS * DIV;
  localparam int REP_CYC      = REPEAT_TICKS * DIV;
`ifdef KEY_EVT_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b1;
  logic o_press, o_release, o_click, o_long, o_repeat, o_held;

  key_event_decoder #(
    .F_CLK        (F_CLK),
    .F_TICK       (F_TICK),
    .LONG_TICKS   (LONG_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key_state (key),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_click     (o_click),
    .o_long      (o_long),
    .o_repeat    (o_repeat),
    .o_held      (o_held)
  );

  always #5 clk = ~clk;

  // Event vector bit order: {press, release, click, long, repeat}
  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;

  // Reference model: events follow from how long the key has been held.
  bit   m_key_prev = 1'b1;
  bit   m_hold     = 1'b0;
  bit   m_held     = 1'b0;
  int   m_fall     = 0;
  int   m_press    = 0;
  int   m_rel      = 0;
  exp_t m_e;
  int   d;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_key_prev = 1'b1;
      m_hold     = 1'b0;
    end else begin
      m_e.cyc = cyc;
      m_e.ev  = 5'b0;
      d = cyc - m_fall;
      if (!m_hold) begin
        if (m_key_prev && !key) begin
          m_e.ev  = 5'b10000;
          m_hold  = 1'b1;
          m_fall  = cyc;
          m_press = m_press + 1;
        end
      end else if (key) begin
        m_e.ev = (d <= LONG_CYC) ? 5'b01100 : 5'b01000;
        m_hold = 1'b0;
        m_rel  = m_rel + 1;
      end else if (d == LONG_CYC) begin
        m_e.ev = 5'b00010;
      end else if (AUTOREP && d > LONG_CYC && ((d - LONG_CYC) % REP_CYC) == 0) begin
        m_e.ev = 5'b00001;
      end
      m_key_prev = key;
      if (m_e.ev != 5'b0) q.push_back(m_e);
    end
    m_held = m_hold;
  end

  // Monitor: samples on the falling edge, pops one expectation per DUT event.
  int         chk = 0;
  int         err = 0;
  int         d_press = 0, d_rel = 0, d_long = 0, d_rep = 0;
  int         d_press_cyc = 0;
  bit         finish_req = 1'b0;
  logic [4:0] ev;
  exp_t       e;

  always @(negedge clk) begin
    ev = {o_press, o_release, o_click, o_long, o_repeat};
    if (rst) begin
      chk = chk + 1;
      if ({ev, o_held} != 6'b0) begin
        err = err + 1;
        $display("FAIL reset_outputs @%0d: got %b want 000000", cyc, {ev, o_held});
      end
    end else begin
      chk = chk + 1;
      if (o_held !== m_held) begin
        err = err + 1;
        $display("FAIL held @%0d: got %b want %b", cyc, o_held, m_held);
      end
      if (ev != 5'b0) begin
        chk = chk + 1;
        if ($countones({ev[4], ev[3], ev[1], ev[0]}) > 1 || (ev[2] && !ev[3])) begin
          err = err + 1;
          $display("FAIL onehot @%0d: got %b want single event", cyc, ev);
        end
        chk = chk + 1;
        if (q.size() == 0) begin
          err = err + 1;
          $display("FAIL unexpected_event @%0d: got %b want none", cyc, ev);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.ev != ev) begin
            err = err + 1;
            $display("FAIL event @%0d: got %b want %b @%0d", cyc, ev, e.ev, e.cyc);
          end
        end
        if (o_press) begin
          d_press     = d_press + 1;
          d_press_cyc = cyc;
        end
        if (o_release) d_rel = d_rel + 1;
        if (o_repeat)  d_rep = d_rep + 1;
        if (o_long) begin
          d_long = d_long + 1;
          chk = chk + 1;
          if (cyc - d_press_cyc != LONG_CYC) begin
            err = err + 1;
            $display("FAIL long_latency: got %0d want %0d", cyc - d_press_cyc, LONG_CYC);
          end
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk = chk + 1;
        err = err + 1;
        $display("FAIL missing_event @%0d: got 00000 want %b", e.cyc, e.ev);
      end
    end

    if (finish_req) begin
      chk = chk + 1;
      if (q.size() != 0) begin
        err = err + 1;
        $display("FAIL leftover_expected: got %0d want 0", q.size());
      end
      chk = chk + 1;
      if (d_press != m_press) begin
        err = err + 1;
        $display("FAIL press_count: got %0d want %0d", d_press, m_press);
      end
      chk = chk + 1;
      if (d_rel != m_rel) begin
        err = err + 1;
        $display("FAIL release_count: got %0d want %0d", d_rel, m_rel);
      end
      chk = chk + 1;
      if (d_long == 0) begin
        err = err + 1;
        $display("FAIL long_seen: got %0d want >0", d_long);
      end
      chk = chk + 1;
      if ((AUTOREP && d_rep == 0) || (!AUTOREP && d_rep != 0)) begin
        err = err + 1;
        $display("FAIL repeat_count: got %0d want %s", d_rep, AUTOREP ? ">0" : "0");
      end
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
    end
  end

  task automatic press_for(input int low, input int high);
    @(negedge clk); #1 key = 1'b0;
    repeat (low) @(negedge clk);
    #1 key = 1'b1;
    repeat (high) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);

    press_for(30, 40);              // short click
    press_for(100, 40);             // long press with repeats
    press_for(LONG_CYC, 40);        // release exactly on the long threshold
    press_for(LONG_CYC + 1, 40);    // release just after the threshold
    press_for(200, 40);             // extended hold
    press_for(1, 5);                // single-cycle press

    // Reset mid-hold, key kept low through reset deassertion
    @(negedge clk); #1 key = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (80) @(negedge clk);
    #1 key = 1'b1;
    repeat (20) @(negedge clk);

    while (cyc < 10500) begin
      int sel, lo, hi;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      lo = LONG_CYC;
      else if (sel == 1) lo = int'($urandom_range(100, 160));
      else               lo = int'($urandom_range(1, 60));
      hi = int'($urandom_range(1, 30));
      press_for(lo, hi);
    end

    repeat (5) @(negedge clk);
    #1 finish_req = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the clean, debounced key level from the key debouncer and turns it into single-cycle event pulses: press, release, short click, long press and auto-repeat.
- Sits between the debouncer output and application logic (counters, menus, display control) in the key-scan path.
- Same clock domain as the debouncer, so there is no input synchroniser.
- Internal millisecond timebase derived from the system clock.

Parameters:
- F_CLK, 50000000, system clock frequency in Hz
- F_TICK, 1000, timebase tick frequency in Hz; DIV = F_CLK/F_TICK, integer, >= 2
- LONG_TICKS, 1000, ticks of continuous hold before the long-press event
- REPEAT_TICKS, 200, ticks between auto-repeat pulses while long-held; >= 1

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_key_state  in  1  debounced key level; 1 = released, 0 = pressed
- o_press  out  1  one-cycle pulse on press detection
- o_release  out  1  one-cycle pulse on release detection
- o_click  out  1  one-cycle pulse on release before the long threshold
- o_long  out  1  one-cycle pulse when the hold reaches LONG_TICKS
- o_repeat  out  1  one-cycle pulse every REPEAT_TICKS after o_long (feature-gated)
- o_held  out  1  level; 1 while in PRESSED or LONG

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; key_q=1; prescaler=0; tick_cnt=0
  - all outputs 0
- Edge detect:
  - key_q registers i_key_state.
  - fall = key_q & ~i_key_state; rise = ~key_q & i_key_state.
  - Event pulses are registered outputs, asserted the cycle after the edge cycle.
  - o_press appears 1 cycle after i_key_state is sampled low.
- Key held through reset deassertion: key_q resets to 1, so the first low sample is treated as a press and o_press fires normally.
- Prescaler:
  - Counts 0..DIV-1 and emits tick when it wraps.
  - Synchronously cleared on fall, so the first tick arrives exactly DIV cycles after the fall cycle.
- tick_cnt:
  - Width $clog2(max(LONG_TICKS,REPEAT_TICKS)+1).
  - Cleared on fall, and on each o_long or o_repeat.
  - Increments on tick in PRESSED/LONG.
  - Never wraps; it is cleared before overflow.
- FSM states and transitions:
  - IDLE: on fall -> PRESSED, o_press=1.
  - PRESSED:
    - rise -> IDLE, o_release=1, o_click=1.
    - Else if tick and tick_cnt==LONG_TICKS-1 -> LONG, o_long=1, tick_cnt=0.
    - o_long is therefore LONG_TICKS*DIV cycles after o_press.
  - LONG:
    - rise -> IDLE, o_release=1, no o_click.
    - Else if tick and tick_cnt==REPEAT_TICKS-1 -> o_repeat=1, tick_cnt=0, stay LONG.
- Simultaneous events:
  - rise in the same cycle as the long threshold: release wins. o_release and o_click fire; o_long does not.
  - rise in the same cycle as the repeat threshold: o_release only.
- At most one of o_press, o_release, o_long, o_repeat is high in any cycle. o_click only coincides with o_release.
- o_held is registered: 1 from the o_press cycle through the cycle before o_release.
- Reset mid-hold: returns to IDLE with no o_release. A still-low key produces a fresh o_press after reset deasserts.

Optional Feature:
- Macro: KEY_EVT_AUTOREPEAT_EN
- Defined: o_repeat is generated as above.
- Undefined:
  - o_repeat is tied to 0.
  - LONG holds with tick_cnt frozen until rise.
  - Repeat compare logic is not built.
  - REPEAT_TICKS is ignored.

Decomposition:
- Package key_event_pkg:
  - typedef enum logic [1:0] key_evt_state_t {IDLE, PRESSED, LONG}
  - function for counter width from LONG_TICKS/REPEAT_TICKS
- Sub-module key_tick_gen:
  - Parameter DIV.
  - Ports i_clk, i_rst, i_clr (sync clear), o_tick (one-cycle pulse).
  - Instantiated once.

Test Plan:
Common bench params unless stated: F_CLK=1000, F_TICK=100 (DIV=10), LONG_TICKS=5, REPEAT_TICKS=2, feature on.
- Short press: drop i_key_state at cycle 100, raise at 130 -> o_press @101; o_release and o_click @131; o_held high 101..130; no o_long.
- Long press with repeat: drop at 100, hold until 200 ->
  - o_long @151
  - o_repeat @171 and @191
  - o_release @201 with o_click=0
- Release on long threshold: drop at 100, raise so rise is detected in cycle 150 -> o_release and o_click @151; o_long never asserted.
- Reset mid-hold: drop at 100, i_rst pulse 120..122 with key still low -> outputs 0 during reset; no o_release; o_press one cycle after first low sample post-reset; o_long 50 cycles later.
- Feature undefined, hold 100..300 -> single o_long @151; o_repeat stays 0; o_release @301.
- Scoreboard: random key waveform, 10k cycles -> press/release counts equal; one-hot event check never violated.
